// File: rtl/key_scan_4x4_pkg.sv
// Shared keypad-scan definitions: FSM states, idle/reset patterns, entry-buffer
// geometry and key-repeat timing used alongside the display constants.
package key_scan_4x4_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      PRESSED  = 2'd2,
      RELEASE  = 2'd3
   } scan_state_t;

   localparam logic [3:0] ROW_RESET      = 4'b1110;
   localparam logic [3:0] COL_IDLE       = 4'hF;
   localparam int         DIGIT_W        = 4;
   localparam int         DIGIT_N        = 6;
   localparam int         ENTRY_W        = DIGIT_W * DIGIT_N;
   localparam logic [3:0] CLEAR_CODE_DEF = 4'd15;

   localparam int REPEAT_DELAY  = 500;
   localparam int REPEAT_PERIOD = 100;
   localparam int RPT_W         = 9;
   localparam logic [RPT_W-1:0] RPT_LAST   = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);

   // {exactly_one_low, column_index}; anything other than a single low bit is rejected
   function automatic logic [2:0] col_decode(input logic [3:0] col);
      case (col)
         4'b1110: return 3'b100;
         4'b1101: return 3'b101;
         4'b1011: return 3'b110;
         4'b0111: return 3'b111;
         default: return 3'b000;
      endcase
   endfunction

   function automatic logic [ENTRY_W-1:0] entry_push(input logic [ENTRY_W-1:0] entry,
                                                     input logic [DIGIT_W-1:0] digit,
                                                     input logic [DIGIT_W-1:0] clear_code);
      if (digit == clear_code)
         return '0;
      return {entry[ENTRY_W-DIGIT_W-1:0], digit};
   endfunction

endpackage

// File: rtl/key_scan_4x4_if.sv
// Keypad matrix lines plus the key/entry outputs handed to the clock-setting logic.
interface key_scan_4x4_if;
   import key_scan_4x4_pkg::*;

   logic [3:0]         col_in;
   logic [3:0]         row_out;
   logic [3:0]         key_code;
   logic               key_valid;
   logic               key_held;
   logic [ENTRY_W-1:0] entry_data;

   modport master (
      output col_in,
      input  row_out, key_code, key_valid, key_held, entry_data
   );

   modport slave (
      input  col_in,
      output row_out, key_code, key_valid, key_held, entry_data
   );
endinterface

// File: rtl/key_scan_4x4_col_sync.sv
// Two-flop synchroniser for the asynchronous keypad column lines; resets to idle.
module key_col_sync (
   input  logic       clk_1khz,
   input  logic       rst_n,
   input  logic [3:0] col_in,
   output logic [3:0] col_sync
);
   logic [3:0] meta_reg;
   logic [3:0] sync_reg;

   always_ff @(posedge clk_1khz or negedge rst_n) begin
      if (!rst_n) begin
         meta_reg <= 4'hF;
         sync_reg <= 4'hF;
      end else begin
         meta_reg <= col_in;
         sync_reg <= meta_reg;
      end
   end

   assign col_sync = sync_reg;
endmodule

// File: rtl/key_scan_4x4.sv
// 4x4 keypad scanner with press/release debounce and a 6-digit entry buffer.
// Define KEY_REPEAT_EN to auto-repeat a held key (500-cycle delay, then every 100).
module key_scan_4x4
   import key_scan_4x4_pkg::*;
#(
   parameter int         ROW_DWELL   = 4,
   parameter int         DEBOUNCE_MS = 20,
   parameter logic [3:0] CLEAR_CODE  = CLEAR_CODE_DEF
) (
   input  logic           clk_1khz,
   input  logic           rst_n,
   key_scan_4x4_if.slave  kp
);
   localparam int DWELL_W = $clog2(ROW_DWELL);
   localparam int DB_W    = $clog2(DEBOUNCE_MS);
   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(ROW_DWELL - 1);
   localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_MS - 1);

   logic [3:0] col_sync;
   logic [2:0] col_dec;

   key_col_sync u_col_sync (
      .clk_1khz (clk_1khz),
      .rst_n    (rst_n),
      .col_in   (kp.col_in),
      .col_sync (col_sync)
   );

   assign col_dec = col_decode(col_sync);

   scan_state_t        state_reg;
   logic [DWELL_W-1:0] dwell_reg;
   logic [DB_W-1:0]    db_cnt_reg;
   logic [3:0]         row_reg;
   logic [1:0]         row_idx_reg;
   logic [3:0]         col_pat_reg;
   logic [1:0]         col_idx_reg;
   logic [3:0]         key_code_reg;
   logic               key_valid_reg;
   logic               key_held_reg;
   logic [ENTRY_W-1:0] entry_reg;
`ifdef KEY_REPEAT_EN
   logic [RPT_W-1:0]   rpt_cnt_reg;
`endif

   always_ff @(posedge clk_1khz or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= SCAN;
         dwell_reg     <= '0;
         db_cnt_reg    <= '0;
         row_reg       <= ROW_RESET;
         row_idx_reg   <= 2'd0;
         col_pat_reg   <= COL_IDLE;
         col_idx_reg   <= 2'd0;
         key_code_reg  <= 4'd0;
         key_valid_reg <= 1'b0;
         key_held_reg  <= 1'b0;
         entry_reg     <= '0;
`ifdef KEY_REPEAT_EN
         rpt_cnt_reg   <= '0;
`endif
      end else begin
         key_valid_reg <= 1'b0;
         case (state_reg)
            SCAN: begin
               if (dwell_reg == DWELL_LAST) begin
                  dwell_reg <= '0;
                  if (col_dec[2]) begin
                     col_pat_reg <= col_sync;
                     col_idx_reg <= col_dec[1:0];
                     db_cnt_reg  <= '0;
                     state_reg   <= DEBOUNCE;
                  end else begin
                     row_reg     <= {row_reg[2:0], row_reg[3]};
                     row_idx_reg <= row_idx_reg + 2'd1;
                  end
               end else begin
                  dwell_reg <= dwell_reg + 1'b1;
               end
            end
            DEBOUNCE: begin
               if (col_sync != col_pat_reg) begin
                  // bounce: rescan the same row from a fresh dwell
                  state_reg  <= SCAN;
                  dwell_reg  <= '0;
                  db_cnt_reg <= '0;
               end else if (db_cnt_reg == DB_LAST) begin
                  state_reg     <= PRESSED;
                  db_cnt_reg    <= '0;
                  key_code_reg  <= {row_idx_reg, col_idx_reg};
                  key_valid_reg <= 1'b1;
                  key_held_reg  <= 1'b1;
                  entry_reg     <= entry_push(entry_reg, {row_idx_reg, col_idx_reg}, CLEAR_CODE);
`ifdef KEY_REPEAT_EN
                  rpt_cnt_reg   <= '0;
`endif
               end else begin
                  db_cnt_reg <= db_cnt_reg + 1'b1;
               end
            end
            PRESSED: begin
               if (col_sync == COL_IDLE) begin
                  state_reg  <= RELEASE;
                  db_cnt_reg <= '0;
`ifdef KEY_REPEAT_EN
                  rpt_cnt_reg <= '0;
               end else if (rpt_cnt_reg == RPT_LAST) begin
                  // reload so the following repeats land every REPEAT_PERIOD cycles
                  rpt_cnt_reg   <= RPT_RELOAD;
                  key_valid_reg <= 1'b1;
                  entry_reg     <= entry_push(entry_reg, key_code_reg, CLEAR_CODE);
               end else begin
                  rpt_cnt_reg <= rpt_cnt_reg + 1'b1;
`endif
               end
            end
            RELEASE: begin
               if (col_sync != COL_IDLE) begin
                  state_reg  <= PRESSED;
                  db_cnt_reg <= '0;
`ifdef KEY_REPEAT_EN
                  rpt_cnt_reg <= '0;
`endif
               end else if (db_cnt_reg == DB_LAST) begin
                  state_reg    <= SCAN;
                  key_held_reg <= 1'b0;
                  db_cnt_reg   <= '0;
                  dwell_reg    <= '0;
                  row_reg      <= {row_reg[2:0], row_reg[3]};
                  row_idx_reg  <= row_idx_reg + 2'd1;
               end else begin
                  db_cnt_reg <= db_cnt_reg + 1'b1;
               end
            end
            default: state_reg <= SCAN;
         endcase
      end
   end

   assign kp.row_out    = row_reg;
   assign kp.key_code   = key_code_reg;
   assign kp.key_valid  = key_valid_reg;
   assign kp.key_held   = key_held_reg;
   assign kp.entry_data = entry_reg;
endmodule

// File: tb/tb_key_scan_4x4.sv
// Bench for key_scan_4x4: a keypad matrix model drives the columns from the row
// strobes; entry contents are predicted from a digit queue.
module tb_key_scan_4x4;
   logic        clk_1khz = 1'b0;
   logic        rst_n    = 1'b0;
   logic [15:0] keys     = 16'd0;
   logic [3:0]  col_model;

   always #5 clk_1khz = ~clk_1khz;

   key_scan_4x4_if ks ();

   key_scan_4x4 dut (
      .clk_1khz (clk_1khz),
      .rst_n    (rst_n),
      .kp       (ks.slave)
   );

   // a pressed key pulls its column low while its row is strobed
   always_comb begin
      col_model = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (!ks.row_out[r] && keys[r*4+c]) col_model[c] = 1'b0;
   end
   assign ks.col_in = col_model;

   int         tests = 0;
   int         fails = 0;
   int         valid_cnt = 0;
   logic [3:0] last_code = 4'd0;
   logic [3:0] digits[$];

   always @(negedge clk_1khz)
      if (ks.key_valid === 1'b1) begin
         valid_cnt++;
         last_code = ks.key_code;
      end

   typedef struct {
      logic [3:0]  code;
      logic [23:0] exp_entry;
   } vec_t;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk_1khz);
      #1;
   endtask

   function automatic void model_key(input logic [3:0] code);
      if (code == 4'd15) digits.delete();
      else begin
         digits.push_back(code);
         if (digits.size() > 6) void'(digits.pop_front());
      end
   endfunction

   function automatic int model_entry();
      int e = 0;
      foreach (digits[i]) e = e * 16 + int'(digits[i]);
      return e;
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      keys  = 16'd0;
      digits.delete();
      repeat (3) tick();
      rst_n = 1'b1;
   endtask

   task automatic wait_valid(input int v0, input int budget, output bit got);
      got = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         tick();
         if (valid_cnt != v0) got = 1'b1;
      end
   endtask

   task automatic wait_release(input string name);
      bit rel = 1'b0;
      for (int i = 0; i < 40 && !rel; i++) begin
         tick();
         if (ks.key_held === 1'b0) rel = 1'b1;
      end
      check({name, " release"}, int'(rel), 1);
   endtask

   task automatic do_press(input logic [3:0] code, input int hold, input string name);
      int v0;
      int reps;
      bit got;
      v0   = valid_cnt;
      keys = 16'd1 << code;
      wait_valid(v0, 39, got);
      check({name, " accept"}, int'(got), 1);
      check({name, " code"}, int'(last_code), int'(code));
      check({name, " held"}, int'(ks.key_held), 1);
      reps = 0;
`ifdef KEY_REPEAT_EN
      if (hold >= 500) reps = (hold - 500) / 100 + 1;
`endif
      for (int i = 0; i <= reps; i++) model_key(code);
      repeat (hold) tick();
      keys = 16'd0;
      wait_release(name);
      check({name, " pulses"}, valid_cnt - v0, 1 + reps);
      check({name, " entry"}, int'(ks.entry_data), model_entry());
      repeat (5) tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[8];
      int   v0;
      int   bad;
      bit   got;
      logic [3:0] rcode;

      tbl = '{'{4'd1, 24'h000001}, '{4'd2, 24'h000012}, '{4'd3, 24'h000123},
              '{4'd4, 24'h001234}, '{4'd5, 24'h012345}, '{4'd6, 24'h123456},
              '{4'd7, 24'h234567}, '{4'd15, 24'h000000}};

      // idle scan: each row strobed for 4 cycles, nothing reported
      do_reset();
      check("reset row_out", int'(ks.row_out), 'hE);
      check("reset key_code", int'(ks.key_code), 0);
      check("reset held", int'(ks.key_held), 0);
      bad = 0;
      v0  = valid_cnt;
      for (int k = 0; k < 100; k++) begin
         if (ks.row_out !== ~(4'd1 << ((k / 4) % 4))) bad++;
         tick();
      end
      check("idle row rotation errors", bad, 0);
      check("idle no valid", valid_cnt - v0, 0);
      check("idle entry", int'(ks.entry_data), 0);

      // row 1 col 2 -> code 6
      do_press(4'd6, 30, "key6");
      check("key6 entry const", int'(ks.entry_data), 'h000006);

      // bounce during debounce and during release
      v0   = valid_cnt;
      keys = 16'd1 << 6;
      repeat (8) tick();
      keys = 16'd0;
      repeat (5) tick();
      keys = 16'd1 << 6;
      repeat (8) tick();
      keys = 16'd0;
      repeat (5) tick();
      keys = 16'd1 << 6;
      wait_valid(v0, 60, got);
      check("bounce accept", int'(got), 1);
      check("bounce code", int'(last_code), 6);
      model_key(4'd6);
      repeat (30) tick();
      keys = 16'd0;
      repeat (5) tick();
      check("bounce held through release bounce", int'(ks.key_held), 1);
      keys = 16'd1 << 6;
      repeat (10) tick();
      keys = 16'd0;
      wait_release("bounce");
      check("bounce pulses", valid_cnt - v0, 1);
      check("bounce entry", int'(ks.entry_data), model_entry());
      repeat (5) tick();

      // digit sequence then clear key
      do_reset();
      for (int i = 0; i < 8; i++) begin
         do_press(tbl[i].code, 30, "tbl");
         check("tbl entry const", int'(ks.entry_data), int'(tbl[i].exp_entry));
      end

      // two keys on one row are rejected
      v0   = valid_cnt;
      keys = (16'd1 << 4) | (16'd1 << 5);
      repeat (100) tick();
      check("two_col no valid", valid_cnt - v0, 0);
      check("two_col not held", int'(ks.key_held), 0);
      keys = 16'd0;
      repeat (5) tick();

      // asynchronous reset while a key is held
      v0   = valid_cnt;
      keys = 16'd1 << 3;
      wait_valid(v0, 39, got);
      check("rst pre accept", int'(got), 1);
      repeat (10) tick();
      rst_n = 1'b0;
      #1;
      check("rst row_out", int'(ks.row_out), 'hE);
      check("rst held", int'(ks.key_held), 0);
      check("rst key_code", int'(ks.key_code), 0);
      check("rst valid", int'(ks.key_valid), 0);
      check("rst entry", int'(ks.entry_data), 0);
      digits.delete();
      repeat (2) tick();
      rst_n = 1'b1;
      v0 = valid_cnt;
      repeat (20) tick();
      check("rst no early valid", valid_cnt - v0, 0);
      wait_valid(v0, 39, got);
      check("rst re-accept", int'(got), 1);
      check("rst re-accept code", int'(last_code), 3);
      model_key(4'd3);
      keys = 16'd0;
      wait_release("rst");
      check("rst entry after", int'(ks.entry_data), model_entry());
      repeat (5) tick();

      // long hold of key 9
      do_reset();
      do_press(4'd9, 750, "hold9");
`ifdef KEY_REPEAT_EN
      check("hold9 entry const", int'(ks.entry_data), 'h009999);
`else
      check("hold9 entry const", int'(ks.entry_data), 'h000009);
`endif

      // random key sequence against the digit-queue model
      for (int n = 0; n < 12; n++) begin
         rcode = 4'($urandom_range(0, 15));
         do_press(rcode, int'($urandom_range(5, 200)), "rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
